// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one WIDTH-bit adder among NREQ requesters
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*WIDTH-1:0]    req_a,
  input  logic [NREQ*WIDTH-1:0]    req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH:0]           rsp_sum,
  output logic [$clog2(NREQ)-1:0]  rsp_id
);
  localparam int IDW = $clog2(NREQ);
  typedef enum logic {IDLE, RESP} state_t;
  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic             hit;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  // Scan from the farthest lane back to ptr so the nearest valid lane wins last.
  always_comb begin
    win = '0;
    hit = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr) + k) % NREQ]) begin
        hit = 1'b1;
        win = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign grant     = !rst && hit && (state == IDLE || rsp_ready);
  assign req_ready = grant ? (NREQ'(1) << win) : '0;
  assign a_sel     = req_a[int'(win)*WIDTH +: WIDTH];
  assign b_sel     = req_b[int'(win)*WIDTH +: WIDTH];
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      rsp_sum <= '0;
      rsp_id  <= '0;
    end else if (grant) begin
      state   <= RESP;
      ptr     <= win == IDW'(NREQ - 1) ? '0 : win + 1'b1;
      rsp_sum <= {1'b0, a_sel} + {1'b0, b_sel};
      rsp_id  <= win;
    end else if (state == RESP && rsp_ready) begin
      state <= IDLE;
    end
  end
endmodule
